// File: rtl/pipeline_hazard_regs_pkg.sv
// Shared constants and types for the fetch/decode/execute pipeline registers.
package pipeline_hazard_regs_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int unsigned CTRL_REG_WRITE = 0;
   localparam int unsigned CTRL_MEM_WRITE = 1;
   localparam int unsigned CTRL_MEM_READ  = 2;

   localparam int unsigned CTRL_W_DEF = 12;

   // Default-width decoded control bundle; reg_write is bit 0.
   typedef struct packed {
      logic [CTRL_W_DEF-4:0] other;
      logic                  mem_read;
      logic                  mem_write;
      logic                  reg_write;
   } ctrl_bundle_t;

endpackage

// File: rtl/pipeline_hazard_regs_pipe_reg_en_clr.sv
// Generic pipeline register with synchronous clear (highest priority) and load enable.
module pipeline_hazard_regs_pipe_reg_en_clr #(
   parameter int unsigned       WIDTH   = 32,
   parameter logic [WIDTH-1:0]  RST_VAL = '0,
   parameter logic [WIDTH-1:0]  CLR_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = CLR_VAL;
      end else if (en) begin
         q_d = d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/pipeline_hazard_regs.sv
// PC, IF/ID and ID/EX registers driven by hazard stall/flush controls, with stall/flush counters.
module pipeline_hazard_regs
   import pipeline_hazard_regs_pkg::*;
#(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      CTRL_W   = 12,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int unsigned      CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stallF,
   input  logic              stallD,
   input  logic              FlushD,
   input  logic              FlushE,
   input  logic [XLEN-1:0]   PCNextF,
   input  logic [31:0]       InstrF,
   output logic [XLEN-1:0]   PCF,
   output logic [31:0]       InstrD,
   output logic [XLEN-1:0]   PCD,
   output logic [XLEN-1:0]   PCPlus4D,
   output logic              ValidD,
   input  logic [CTRL_W-1:0] CtrlD,
   input  logic [XLEN-1:0]   RD1D,
   input  logic [XLEN-1:0]   RD2D,
   input  logic [XLEN-1:0]   ImmExtD,
   input  logic [4:0]        Rs1D,
   input  logic [4:0]        Rs2D,
   input  logic [4:0]        RdD,
   output logic [CTRL_W-1:0] CtrlE,
   output logic [XLEN-1:0]   RD1E,
   output logic [XLEN-1:0]   RD2E,
   output logic [XLEN-1:0]   ImmExtE,
   output logic [XLEN-1:0]   PCE,
   output logic [XLEN-1:0]   PCPlus4E,
   output logic [4:0]        Rs1E,
   output logic [4:0]        Rs2E,
   output logic [4:0]        RdE,
   output logic              ValidE,
   output logic              MemReadE,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int unsigned IFID_W = 32 + 2 * XLEN + 1;
   localparam int unsigned IDEX_W = CTRL_W + 5 * XLEN + 3 * 5 + 1;

   // A flushed IF/ID slot holds a NOP with zeroed PCs and a cleared valid bit.
   localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INSTR, {(2 * XLEN + 1){1'b0}}};

   logic [XLEN-1:0]   pcf;
   logic [XLEN-1:0]   pc_plus4_f;
   logic [IFID_W-1:0] ifid_d;
   logic [IFID_W-1:0] ifid_q;
   logic [IDEX_W-1:0] idex_d;
   logic [IDEX_W-1:0] idex_q;

   pipeline_hazard_regs_pipe_reg_en_clr #(
      .WIDTH   (XLEN),
      .RST_VAL (RESET_PC),
      .CLR_VAL (RESET_PC)
   ) u_pc_reg (
      .clk   (clk),
      .reset (reset),
      .en    (~stallF),
      .clr   (1'b0),
      .d     (PCNextF),
      .q     (pcf)
   );

   assign pc_plus4_f = pcf + XLEN'(4);
   assign ifid_d     = {InstrF, pcf, pc_plus4_f, 1'b1};

   pipeline_hazard_regs_pipe_reg_en_clr #(
      .WIDTH   (IFID_W),
      .RST_VAL (IFID_BUBBLE),
      .CLR_VAL (IFID_BUBBLE)
   ) u_ifid_reg (
      .clk   (clk),
      .reset (reset),
      .en    (~stallD),
      .clr   (FlushD),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign PCF = pcf;
   assign {InstrD, PCD, PCPlus4D, ValidD} = ifid_q;

   // ID/EX never stalls; a flush turns the slot into an all-zero bubble.
   assign idex_d = {CtrlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD};

   pipeline_hazard_regs_pipe_reg_en_clr #(
      .WIDTH   (IDEX_W),
      .RST_VAL ('0),
      .CLR_VAL ('0)
   ) u_idex_reg (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .clr   (FlushE),
      .d     (idex_d),
      .q     (idex_q)
   );

   assign {CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE} = idex_q;
   assign MemReadE = CtrlE[CTRL_MEM_READ];

   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d;

   // Free-running wrap-around event counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stallD) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (FlushD) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_regs.sv
// Scoreboard bench for pipeline_hazard_regs: directed vectors push expectations, a monitor compares.
module tb_pipeline_hazard_regs;
   import pipeline_hazard_regs_pkg::*;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned CTRL_W = 12;
   localparam int unsigned CNT_W  = 4;

   localparam logic [11:0] C_RW = 12'(1) << CTRL_REG_WRITE;
   localparam logic [11:0] C_MW = 12'(1) << CTRL_MEM_WRITE;
   localparam logic [11:0] C_MR = 12'(1) << CTRL_MEM_READ;

   logic              clk;
   logic              reset;
   logic              stallF, stallD, FlushD, FlushE;
   logic [XLEN-1:0]   PCNextF;
   logic [31:0]       InstrF;
   logic [XLEN-1:0]   PCF, PCD, PCPlus4D;
   logic [31:0]       InstrD;
   logic              ValidD;
   logic [CTRL_W-1:0] CtrlD;
   logic [XLEN-1:0]   RD1D, RD2D, ImmExtD;
   logic [4:0]        Rs1D, Rs2D, RdD;
   logic [CTRL_W-1:0] CtrlE;
   logic [XLEN-1:0]   RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]        Rs1E, Rs2E, RdE;
   logic              ValidE, MemReadE;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   pipeline_hazard_regs #(
      .XLEN(XLEN), .CTRL_W(CTRL_W), .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .stallF(stallF), .stallD(stallD), .FlushD(FlushD), .FlushE(FlushE),
      .PCNextF(PCNextF), .InstrF(InstrF),
      .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
      .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .ValidE(ValidE), .MemReadE(MemReadE),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] pcf, instrd, pcd, p4d;
      logic        vd;
      logic [11:0] ctrle;
      logic [31:0] rd1e, rd2e, pce, p4e;
      logic [4:0]  rde;
      logic        ve, mre;
      logic [3:0]  sc, fc;
   } exp_t;

   exp_t q[$];
   event async_ev;
   int   errors = 0;
   int   checks = 0;

   function automatic exp_t mk(input logic [31:0] pcf, instrd, pcd, p4d, input logic vd,
                               input logic [11:0] ctrle, input logic [31:0] rd1e, rd2e, pce, p4e,
                               input logic [4:0] rde, input logic ve, mre,
                               input logic [3:0] sc, fc);
      exp_t e;
      e.name = "";
      e.pcf = pcf; e.instrd = instrd; e.pcd = pcd; e.p4d = p4d; e.vd = vd;
      e.ctrle = ctrle; e.rd1e = rd1e; e.rd2e = rd2e; e.pce = pce; e.p4e = p4e;
      e.rde = rde; e.ve = ve; e.mre = mre; e.sc = sc; e.fc = fc;
      return e;
   endfunction

   task automatic chk(input string vec, input string fld, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %h want %h at %0t", vec, fld, act, exp, $time);
      end
   endtask

   // Monitor: each clock edge (or async reset probe) pops one expectation and compares.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or async_ev);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "PCF",       PCF,             e.pcf);
            chk(e.name, "InstrD",    InstrD,          e.instrd);
            chk(e.name, "PCD",       PCD,             e.pcd);
            chk(e.name, "PCPlus4D",  PCPlus4D,        e.p4d);
            chk(e.name, "ValidD",    32'(ValidD),     32'(e.vd));
            chk(e.name, "CtrlE",     32'(CtrlE),      32'(e.ctrle));
            chk(e.name, "RD1E",      RD1E,            e.rd1e);
            chk(e.name, "RD2E",      RD2E,            e.rd2e);
            chk(e.name, "PCE",       PCE,             e.pce);
            chk(e.name, "PCPlus4E",  PCPlus4E,        e.p4e);
            chk(e.name, "RdE",       32'(RdE),        32'(e.rde));
            chk(e.name, "ValidE",    32'(ValidE),     32'(e.ve));
            chk(e.name, "MemReadE",  32'(MemReadE),   32'(e.mre));
            chk(e.name, "stall_cnt", 32'(stall_cnt),  32'(e.sc));
            chk(e.name, "flush_cnt", 32'(flush_cnt),  32'(e.fc));
         end
      end
   end

   // Drive one cycle's inputs at a falling edge, queue the post-edge expectation, advance.
   task automatic cyc(input string nm, input logic sf, sd, fd, fe,
                      input logic [31:0] pcn, instr, input logic [11:0] ctrl,
                      input logic [31:0] rd1, input logic [4:0] rd, input exp_t e);
      stallF = sf; stallD = sd; FlushD = fd; FlushE = fe;
      PCNextF = pcn; InstrF = instr; CtrlD = ctrl; RD1D = rd1; RdD = rd;
      e.name = nm;
      q.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t r;
      r = mk(32'h0, NOP_INSTR, 32'h0, 32'h0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0, 32'h0,
             5'd0, 1'b0, 1'b0, 4'd0, 4'd0);
      reset = 1'b1;
      stallF = 1'b0; stallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
      PCNextF = '0; InstrF = NOP_INSTR; CtrlD = '0; RD1D = '0; RdD = '0;
      RD2D = 32'h22; ImmExtD = 32'h33; Rs1D = 5'd2; Rs2D = 5'd3;

      @(negedge clk);
      r.name = "init_rst";
      q.push_back(r);
      -> async_ev;
      @(negedge clk);
      reset = 1'b0;

      // Straight-line fetch of A, B
      cyc("sl1", 0,0,0,0, 32'h4, 32'hA000_0001, 12'h0, 32'h0, 5'd0,
          mk(32'h4, 32'hA000_0001, 32'h0, 32'h4, 1, 12'h0, 32'h0, 32'h22, 32'h0, 32'h0, 5'd0, 0, 0, 4'd0, 4'd0));
      cyc("sl2", 0,0,0,0, 32'h8, 32'hB000_0002, C_RW|C_MR, 32'hA1, 5'd5,
          mk(32'h8, 32'hB000_0002, 32'h4, 32'h8, 1, 12'h005, 32'hA1, 32'h22, 32'h0, 32'h4, 5'd5, 1, 1, 4'd0, 4'd0));
      // Load-use: hold PC and IF/ID, bubble into EX
      cyc("lduse", 1,1,0,1, 32'hC, 32'hC000_0003, C_RW|C_MW, 32'hB1, 5'd6,
          mk(32'h8, 32'hB000_0002, 32'h4, 32'h8, 1, 12'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 4'd1, 4'd0));
      cyc("lduse_re", 0,0,0,0, 32'hC, 32'hC000_0003, C_RW|C_MW, 32'hB1, 5'd6,
          mk(32'hC, 32'hC000_0003, 32'h8, 32'hC, 1, 12'h003, 32'hB1, 32'h22, 32'h4, 32'h8, 5'd6, 1, 0, 4'd1, 4'd0));
      // Taken branch: both D and E flushed
      cyc("branch", 0,0,1,1, 32'h100, 32'hD000_0004, C_MR, 32'hC1, 5'd7,
          mk(32'h100, NOP_INSTR, 32'h0, 32'h0, 0, 12'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 4'd1, 4'd1));
      cyc("br_tgt", 0,0,0,0, 32'h104, 32'hD000_0004, 12'h0, 32'h0, 5'd0,
          mk(32'h104, 32'hD000_0004, 32'h100, 32'h104, 1, 12'h0, 32'h0, 32'h22, 32'h0, 32'h0, 5'd0, 0, 0, 4'd1, 4'd1));
      // stallD and FlushD together: flush wins, both counters step
      cyc("conflict", 0,1,1,0, 32'h108, 32'hE000_0005, C_MW|C_MR, 32'hD1, 5'd8,
          mk(32'h108, NOP_INSTR, 32'h0, 32'h0, 0, 12'h006, 32'hD1, 32'h22, 32'h100, 32'h104, 5'd8, 1, 1, 4'd2, 4'd2));
      cyc("pre_wrap", 0,0,0,0, 32'hFFFF_FFFC, 32'hF000_0006, 12'h0, 32'h0, 5'd0,
          mk(32'hFFFF_FFFC, 32'hF000_0006, 32'h108, 32'h10C, 1, 12'h0, 32'h0, 32'h22, 32'h0, 32'h0, 5'd0, 0, 0, 4'd2, 4'd2));
      // PC+4 wraps to zero
      cyc("pc_wrap", 0,0,0,0, 32'h0, 32'h1234_5678, C_RW, 32'h55, 5'd9,
          mk(32'h0, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0, 1, 12'h001, 32'h55, 32'h22, 32'h108, 32'h10C, 5'd9, 1, 0, 4'd2, 4'd2));

      // Asynchronous reset asserted mid-cycle
      #2;
      reset = 1'b1;
      r.name = "async_rst";
      q.push_back(r);
      -> async_ev;
      @(negedge clk);
      cyc("rst_hold", 1,1,1,1, 32'h80, 32'h99, C_MR, 32'h77, 5'd3, r);
      reset = 1'b0;
      cyc("post_rst", 0,0,0,0, 32'h40, 32'h1111_1111, 12'h0, 32'h0, 5'd0,
          mk(32'h40, 32'h1111_1111, 32'h0, 32'h4, 1, 12'h0, 32'h0, 32'h22, 32'h0, 32'h0, 5'd0, 0, 0, 4'd0, 4'd0));
      // 17 stall edges on a 4-bit counter end at 1
      for (int k = 1; k <= 17; k++) begin
         cyc("cnt_wrap", 1,1,0,0, 32'h80, 32'h99, 12'h0, 32'h0, 5'd0,
             mk(32'h40, 32'h1111_1111, 32'h0, 32'h4, 1, 12'h0, 32'h0, 32'h22, 32'h0, 32'h4, 5'd0, 1, 0, 4'(k % 16), 4'd0));
      end

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expectations want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
